// File: rtl/dpram_march_bist.sv
// March-style BIST initiator for one port of dual_port_ram.
// Up-write/up-read, then complement down-write/down-read, with first-fail capture.
module dpram_march_bist #(
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN      = 8'hA5,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_enable,
  output logic                  ram_output_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] err_data
);

  localparam logic [ADDR_WIDTH-1:0] AMAX  = '1;
  localparam logic [1:0]            LLAST = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, W_UP, R_UP, DRAIN_UP,
    W_DOWN, R_DOWN, DRAIN_DOWN, DONE
  } state_e;

  typedef struct packed {
    logic                  v;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] e;
  } rd_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            lat_q, lat_d;
  rd_t                   pipe_q [READ_LATENCY];
  rd_t                   pipe_d [READ_LATENCY];
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] eaddr_q, eaddr_d;
  logic [DATA_WIDTH-1:0] edata_q, edata_d;
  logic                  pass_q, pass_d;

  logic                  accept;
  logic                  lat_last;
  logic                  rd_issue;
  logic                  mism;
  logic [DATA_WIDTH-1:0] pat;

  assign pat      = PATTERN ^ DATA_WIDTH'(addr_q);
  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign lat_last = (lat_q == LLAST);
  assign rd_issue = (state_q == R_UP) || (state_q == R_DOWN);
  assign mism     = pipe_q[READ_LATENCY-1].v &&
                    (ram_data_out != pipe_q[READ_LATENCY-1].e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lat_q   <= '0;
      cnt_q   <= '0;
      eaddr_q <= '0;
      edata_q <= '0;
      pass_q  <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      eaddr_q <= eaddr_d;
      edata_q <= edata_d;
      pass_q  <= pass_d;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = W_UP;
      W_UP:       if (addr_q == AMAX) state_d = R_UP;
      R_UP:       if (addr_q == AMAX) state_d = DRAIN_UP;
      DRAIN_UP:   if (lat_last) state_d = W_DOWN;
      W_DOWN:     if (addr_q == '0) state_d = R_DOWN;
      R_DOWN:     if (addr_q == '0) state_d = DRAIN_DOWN;
      DRAIN_DOWN: if (lat_last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Address never wraps inside a phase; phase entry reloads it.
  always_comb begin
    addr_d = addr_q;
    lat_d  = '0;
    unique case (state_q)
      IDLE, DONE: addr_d = '0;
      W_UP:
        addr_d = (addr_q == AMAX) ? '0 : addr_q + 1'b1;
      R_UP:
        if (addr_q != AMAX) addr_d = addr_q + 1'b1;
      DRAIN_UP: begin
        lat_d = lat_last ? 2'd0 : lat_q + 2'd1;
        if (lat_last) addr_d = AMAX;
      end
      W_DOWN:
        addr_d = (addr_q == '0) ? AMAX : addr_q - 1'b1;
      R_DOWN:
        if (addr_q != '0) addr_d = addr_q - 1'b1;
      DRAIN_DOWN:
        lat_d = lat_last ? 2'd0 : lat_q + 2'd1;
      default: ;
    endcase
  end

  always_comb begin
    pipe_d[0].v = rd_issue;
    pipe_d[0].a = addr_q;
    pipe_d[0].e = (state_q == R_DOWN) ? ~pat : pat;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    cnt_d   = cnt_q;
    eaddr_d = eaddr_q;
    edata_d = edata_q;
    pass_d  = pass_q;
    if (accept) begin
      cnt_d   = '0;
      eaddr_d = '0;
      edata_d = '0;
      pass_d  = 1'b0;
    end else begin
      if (mism) begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'h00) begin
          eaddr_d = pipe_q[READ_LATENCY-1].a;
          edata_d = ram_data_out;
        end
      end
      if (state_q == DRAIN_DOWN && lat_last) pass_d = (cnt_d == 8'h00);
    end
  end

  always_comb begin
    ram_address       = '0;
    ram_data_in       = '0;
    ram_write_enable  = 1'b0;
    ram_output_enable = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    unique case (state_q)
      IDLE: ;
      W_UP: begin
        ram_address      = addr_q;
        ram_data_in      = pat;
        ram_write_enable = 1'b1;
        busy             = 1'b1;
      end
      R_UP, R_DOWN: begin
        ram_address       = addr_q;
        ram_output_enable = 1'b1;
        busy              = 1'b1;
      end
      DRAIN_UP, DRAIN_DOWN: begin
        ram_address = addr_q;
        busy        = 1'b1;
      end
      W_DOWN: begin
        ram_address      = addr_q;
        ram_data_in      = ~pat;
        ram_write_enable = 1'b1;
        busy             = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign pass      = pass_q;
  assign err_count = cnt_q;
  assign err_addr  = eaddr_q;
  assign err_data  = edata_q;

endmodule

// File: tb/tb_dpram_march_bist.sv
// Bench for dpram_march_bist: faulty RAM models, table vectors,
// hand sequences and randomized faults against an array-level march model.
module tb_dpram_march_bist;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start1 = 1'b0;
  logic start3 = 1'b0;

  logic [AW-1:0] a1, a3, ea1, ea3;
  logic [DW-1:0] di1, di3, do1, do3, ed1, ed3;
  logic we1, we3, oe1, oe3;
  logic busy1, busy3, done1, done3, pass1, pass3;
  logic [7:0] ec1, ec3;

  dpram_march_bist #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .PATTERN(8'hA5), .READ_LATENCY(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .ram_data_out(do1), .ram_address(a1),
    .ram_data_in(di1), .ram_write_enable(we1),
    .ram_output_enable(oe1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(ec1),
    .err_addr(ea1), .err_data(ed1)
  );

  dpram_march_bist #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .PATTERN(8'hA5), .READ_LATENCY(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .ram_data_out(do3), .ram_address(a3),
    .ram_data_in(di3), .ram_write_enable(we3),
    .ram_output_enable(oe3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(ec3),
    .err_addr(ea3), .err_data(ed3)
  );

  int checks = 0;
  int failures = 0;

  // fault: 0 none, 1 stuck bit at address fa, 2 address fa aliases to fb
  int   fmode = 0;
  int   fa = 0;
  int   fb = 0;
  int   fbit = 0;
  logic fval = 1'b0;

  function automatic int phys(int a);
    return (fmode == 2 && a == fa) ? fb : a;
  endfunction

  function automatic logic [7:0] flt(int a, logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (fmode == 1 && a == fa) r[fbit] = fval;
    return r;
  endfunction

  // RAM models: data is only driven in its valid cycle, garbage otherwise
  logic [7:0] garb = 8'h00;
  logic [7:0] mem1 [D];
  logic [7:0] mem3 [D];
  logic       rdv1 = 1'b0;
  logic [7:0] rdd1 = 8'h00;
  logic       rdv3 [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] rdd3 [3];

  always @(posedge clk) begin
    garb <= 8'($urandom);
    if (we1) mem1[phys(int'(a1))] <= di1;
    rdv1 <= oe1;
    rdd1 <= flt(int'(a1), mem1[phys(int'(a1))]);
    if (we3) mem3[phys(int'(a3))] <= di3;
    rdv3[0] <= oe3;
    rdd3[0] <= flt(int'(a3), mem3[phys(int'(a3))]);
    for (int i = 1; i < 3; i++) begin
      rdv3[i] <= rdv3[i-1];
      rdd3[i] <= rdd3[i-1];
    end
  end

  assign do1 = rdv1 ? rdd1 : garb;
  assign do3 = rdv3[2] ? rdd3[2] : garb;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((we1 && oe1) || (we3 && oe3)) begin
        failures++;
        $display("FAIL enables_exclusive got we1=%b oe1=%b we3=%b oe3=%b want not both", we1, oe1, we3, oe3);
      end
    end
  end

  // selected-DUT view
  int sel = 1;
  logic s_busy, s_done, s_pass, s_we, s_oe;
  logic [7:0] s_ec;
  logic [AW-1:0] s_ea, s_a;
  logic [DW-1:0] s_ed, s_di;
  assign s_busy = (sel == 3) ? busy3 : busy1;
  assign s_done = (sel == 3) ? done3 : done1;
  assign s_pass = (sel == 3) ? pass3 : pass1;
  assign s_we   = (sel == 3) ? we3 : we1;
  assign s_oe   = (sel == 3) ? oe3 : oe1;
  assign s_ec   = (sel == 3) ? ec3 : ec1;
  assign s_ea   = (sel == 3) ? ea3 : ea1;
  assign s_a    = (sel == 3) ? a3 : a1;
  assign s_ed   = (sel == 3) ? ed3 : ed1;
  assign s_di   = (sel == 3) ? di3 : di1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic set_start(input logic b);
    if (sel == 3) start3 = b;
    else start1 = b;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, int'(s_busy), 0);
    chk({tag, ".done"}, int'(s_done), 0);
    chk({tag, ".pass"}, int'(s_pass), 0);
    chk({tag, ".err_count"}, int'(s_ec), 0);
    chk({tag, ".err_addr"}, int'(s_ea), 0);
    chk({tag, ".err_data"}, int'(s_ed), 0);
    chk({tag, ".addr"}, int'(s_a), 0);
    chk({tag, ".wdata"}, int'(s_di), 0);
    chk({tag, ".enables"}, int'({s_we, s_oe}), 0);
  endtask

  // pulse start (edge 0), optional second pulse at edge re; count to done
  task automatic run(input int re, output int edges, output int bcnt);
    set_start(1'b1);
    @(posedge clk); #1;
    edges = 0;
    bcnt = 0;
    while (!s_done && edges < 400) begin
      set_start(re > 0 && edges + 1 == re);
      if (s_busy) bcnt++;
      @(posedge clk); #1;
      edges++;
    end
    set_start(1'b0);
  endtask

  // whole-array march with the same fault rules, no cycle timing
  task automatic model(output int cnt, output int ea, output int ed);
    logic [7:0] m [D];
    logic [7:0] e, v;
    cnt = 0; ea = 0; ed = 0;
    for (int a = 0; a < D; a++) m[phys(a)] = 8'hA5 ^ 8'(a);
    for (int a = 0; a < D; a++) begin
      e = 8'hA5 ^ 8'(a);
      v = flt(a, m[phys(a)]);
      if (v != e) begin
        if (cnt == 0) begin ea = a; ed = int'(v); end
        cnt++;
      end
    end
    for (int a = D - 1; a >= 0; a--) m[phys(a)] = ~(8'hA5 ^ 8'(a));
    for (int a = D - 1; a >= 0; a--) begin
      e = ~(8'hA5 ^ 8'(a));
      v = flt(a, m[phys(a)]);
      if (v != e) begin
        if (cnt == 0) begin ea = a; ed = int'(v); end
        cnt++;
      end
    end
  endtask

  task automatic verify(input string tag, input int edges, input int bcnt,
                        input int ecnt, input int eaddr, input int edata);
    int lat;
    lat = sel;
    chk({tag, ".done_edge"}, edges, 4 * D + 2 * lat);
    chk({tag, ".busy_cycles"}, bcnt, 4 * D + 2 * lat);
    chk({tag, ".done"}, int'(s_done), 1);
    chk({tag, ".busy_low"}, int'(s_busy), 0);
    chk({tag, ".pass"}, int'(s_pass), (ecnt == 0) ? 1 : 0);
    chk({tag, ".err_count"}, int'(s_ec), (ecnt > 255) ? 255 : ecnt);
    chk({tag, ".err_addr"}, int'(s_ea), eaddr);
    chk({tag, ".err_data"}, int'(s_ed), edata);
    chk({tag, ".idle_addr"}, int'(s_a), 0);
    chk({tag, ".idle_en"}, int'({s_we, s_oe}), 0);
  endtask

  typedef struct {
    int mode; int fa; int fb; int fbit; int fval; int lat;
    int cnt; int ea; int ed;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int edges, bcnt, ecnt, eaddr, edata;

    tbl[0] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1] = '{1, 9, 0, 3, 1, 1, 1, 9, 'h5B};
    tbl[2] = '{2, 12, 4, 0, 0, 1, 2, 4, 'hA9};
    tbl[3] = '{0, 0, 0, 0, 0, 3, 0, 0, 0};

    for (int i = 0; i < D; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end

    repeat (3) @(posedge clk);
    #1;
    sel = 1; #1; chk_zero("reset_l1");
    sel = 3; #1; chk_zero("reset_l3");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      fmode = tbl[i].mode; fa = tbl[i].fa; fb = tbl[i].fb;
      fbit = tbl[i].fbit; fval = tbl[i].fval[0];
      sel = tbl[i].lat;
      run(0, edges, bcnt);
      verify($sformatf("tbl%0d", i), edges, bcnt,
             tbl[i].cnt, tbl[i].ea, tbl[i].ed);
      @(posedge clk); #1;
    end

    // stray start mid-run, then a start while done
    fmode = 0; sel = 1;
    run(20, edges, bcnt);
    verify("restart_ignored", edges, bcnt, 0, 0, 0);
    run(0, edges, bcnt);
    verify("start_from_done", edges, bcnt, 0, 0, 0);

    // asynchronous abort at edge 30
    fmode = 1; fa = 3; fbit = 0; fval = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort.busy_before", int'(busy1), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("abort_hold");
    rst_n = 1'b1;
    fmode = 0;
    @(posedge clk); #1;
    run(0, edges, bcnt);
    verify("after_abort", edges, bcnt, 0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      fmode = $urandom_range(0, 2);
      fa    = $urandom_range(0, D - 1);
      fb    = (fa + $urandom_range(1, D - 1)) % D;
      fbit  = $urandom_range(0, 7);
      fval  = 1'($urandom_range(0, 1));
      sel   = ($urandom_range(0, 1) == 1) ? 3 : 1;
      model(ecnt, eaddr, edata);
      run(0, edges, bcnt);
      verify($sformatf("rand%0d", r), edges, bcnt, ecnt, eaddr, edata);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_march_bist.md
Name: dpram_march_bist

Overview:
- Built-in self-test initiator that drives one port of dual_port_ram and checks it.
- It writes an address-dependent pattern over the whole array, reads it back, writes the complement in descending order, then reads that back.
- Every read is compared against the expected word, and the block reports pass/fail with the first failing address and data.
- It sits between the system control logic and port A or port B of dual_port_ram. It needs exclusive ownership of that port while busy.

Parameters:
ADDR_WIDTH, 8, RAM address width; DEPTH = 2**ADDR_WIDTH words tested
DATA_WIDTH, 8, RAM data width
PATTERN, 8'hA5, background value; expected word = PATTERN ^ address (address zero-extended/truncated to DATA_WIDTH)
READ_LATENCY, 1, clock edges from RAM sampling read address to ram_data_out valid; legal range 1..3

Ports:
clk  in  1  single clock for the block and the attached RAM port
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a test run when idle or done
ram_data_out  in  DATA_WIDTH  read data from the RAM port
ram_address  out  ADDR_WIDTH  RAM port address
ram_data_in  out  DATA_WIDTH  RAM port write data
ram_write_enable  out  1  RAM port write enable
ram_output_enable  out  1  RAM port output (read) enable
busy  out  1  high from the cycle after start is accepted until done rises
done  out  1  high once a run completes; held until the next accepted start or reset
pass  out  1  valid with done; 1 means zero mismatches
err_count  out  8  mismatch count, saturates at 255
err_addr  out  ADDR_WIDTH  address of the first mismatch
err_data  out  DATA_WIDTH  data read at the first mismatch

Behaviour:
- Async reset: all outputs 0, state IDLE, read pipeline cleared. Reset mid-run aborts immediately and does not resume.
- States are IDLE, W_UP, R_UP, DRAIN_UP, W_DOWN, R_DOWN, DRAIN_DOWN, DONE.
- start sampled high in IDLE or DONE at edge 0 does the following:
  - clears done, pass, err_count, err_addr, err_data;
  - sets busy;
  - enters W_UP.
- start is ignored in all other states.
- W_UP runs for DEPTH cycles, addresses 0 up to DEPTH-1:
  - ram_write_enable=1, ram_output_enable=0;
  - ram_data_in = PATTERN^addr.
- R_UP runs for DEPTH cycles, addresses ascending:
  - ram_write_enable=0, ram_output_enable=1;
  - expected value = PATTERN^addr.
- DRAIN_UP runs for READ_LATENCY cycles. Both enables are 0 and the address holds its last value.
- W_DOWN runs for DEPTH cycles, addresses DEPTH-1 down to 0. Data = ~(PATTERN^addr).
- R_DOWN runs for DEPTH cycles, addresses descending. Expected value = ~(PATTERN^addr).
- DRAIN_DOWN runs for READ_LATENCY cycles, then the block enters DONE.
- Read pipeline:
  - Each read cycle pushes {valid, addr, expected} into a READ_LATENCY-deep shift register.
  - The entry issued in cycle k is compared with ram_data_out at edge k+READ_LATENCY.
  - Pipeline comparisons continue through the drain states.
- On a mismatch:
  - err_count increments (saturating at 255);
  - on the first mismatch only, err_addr and err_data are captured.
- Timing (D = DEPTH, L = READ_LATENCY), counting the start-sampling edge as 0:
  - writes are sampled by the RAM at edges 1..D;
  - R_UP addresses are sampled at edges D+1..2D;
  - W_DOWN occupies cycles 2D+L+1..3D+L;
  - R_DOWN occupies cycles 3D+L+1..4D+L;
  - the final compare and the DONE entry both occur at edge 4D+2L.
- At edge 4D+2L: done=1, busy=0, pass=(err_count==0 including the final compare).
- In IDLE and DONE, both RAM enables are 0 and ram_address=0.
- Address counter: up-count stops at DEPTH-1 and down-count stops at 0. It never wraps across a phase boundary.
- The RAM enables are never both high in the same cycle.

Test Plan:
- Fault-free RAM model, ADDR_WIDTH=4, L=1, start pulse -> done rises at edge 66 with pass=1 and err_count=0; busy is high for exactly 66 cycles.
- RAM model with bit 3 of addr 9 stuck at 1, PATTERN=A5 -> W_UP writes AC, and R_UP reads AC (bit 3 already 1, no error). W_DOWN writes 53 and R_DOWN reads 5B -> pass=0, err_count=1, err_addr=9, err_data=5B.
- Address alias model (addr 12 maps to 4) -> first mismatch err_addr=4, err_data=A9 (expected A1), err_count>=2.
- rst_n low at edge 30 -> all outputs 0 asynchronously. A later start runs the full sequence and reaches done at edge 66 after the new start.
- start pulsed again at edge 20 during a run -> ignored, done still at edge 66. A start while done=1 -> done clears and a new run begins.
- L=3, fault-free model, ADDR_WIDTH=4 -> done at edge 70, pass=1. Check that each comparison occurs exactly 3 edges after its address was sampled.
